switch_debouncer: RTL and testbench
===================================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive synchronized cycles an input must hold a new level before acceptance; legal range 2..65535.
REQ-002 Parameter REPEAT_CYCLES, default 8: auto-repeat period in clock cycles; legal range 2..65535; used only when KEY_AUTOREPEAT_EN is defined.
REQ-003 clock  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 key_n  input  1  raw push-button level, asynchronous, active-low (0 = pressed).
REQ-006 sw  input  4  raw slide-switch levels, asynchronous.
REQ-007 key_pressed  output  1  debounced button level, active-high.
REQ-008 key_pulse  output  1  one-cycle strobe per accepted press (and per repeat when enabled).
REQ-009 switch  output  4  debounced switch levels.
REQ-010 switch_changed  output  1  one-cycle strobe when any switch bit is accepted at a new level.

Function
REQ-011 Each of the 5 raw inputs SHALL pass through its own two-flop synchronizer; key_n SHALL be inverted after synchronization, giving a synchronized sample s per bit.
REQ-012 Each bit SHALL hold a debounced level d and a counter c sized for DEBOUNCE_CYCLES.
REQ-013 If s == d, c SHALL clear to 0.
REQ-014 If s != d and c < DEBOUNCE_CYCLES-1, c SHALL increment by 1.
REQ-015 If s != d and c == DEBOUNCE_CYCLES-1, d SHALL take s and c SHALL clear to 0.
REQ-016 A raw level that stays stable SHALL appear on d at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples it as edge 1.
REQ-017 A raw excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL leave d unchanged and clear c on return.
REQ-018 Counters SHALL never wrap; c SHALL saturate at DEBOUNCE_CYCLES-1 by construction of REQ-015.
REQ-019 key_pressed and switch SHALL be the registered d values, with no combinational path from the raw inputs.
REQ-020 key_pulse SHALL be high for exactly one cycle, in the cycle after key_pressed rises; a key_pressed fall SHALL produce no pulse.
REQ-021 switch_changed SHALL be high for exactly one cycle after any switch bit changes d; several bits changing on the same edge SHALL produce a single one-cycle strobe.
REQ-022 Key and switch paths SHALL be independent; simultaneous events SHALL each produce their own strobe in the same cycle.

Reset
REQ-023 While reset is high, synchronizer flops SHALL load the idle value (key released, switches 0), all c SHALL be 0, and all d SHALL be 0.
REQ-024 While reset is high, key_pressed, key_pulse, switch, switch_changed, and the repeat counter SHALL all be 0.
REQ-025 Reset asserted mid-debounce SHALL discard partial counts; after release, a raw level that differs from the reset values SHALL be re-debounced per REQ-016 and SHALL generate its strobe normally.

Configuration
REQ-026 Macro SWITCH_DEBOUNCER_KEY_AUTOREPEAT_EN compiled in: while key_pressed stays high, a repeat counter SHALL count clock cycles from 0 starting the cycle after the initial key_pulse.
REQ-027 With the macro compiled in, each time the repeat counter reaches REPEAT_CYCLES-1, key_pulse SHALL assert for one cycle and the counter SHALL wrap to 0.
REQ-028 With the macro compiled in, a fall of key_pressed SHALL clear the repeat counter immediately.
REQ-029 Macro not defined: no repeat counter SHALL exist, and key_pulse SHALL fire only per REQ-020.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-030 Scenario 1: after reset, drive sw 0000 -> 0101, hold -> switch = 0101 at edge 6, switch_changed high one cycle only, key outputs stay 0.
REQ-031 Scenario 2: key_n low for 3 cycles, then high -> key_pressed and key_pulse never assert.
REQ-032 Scenario 3: key_n bounces low/high every cycle for 10 cycles, then stays low -> exactly one key_pulse; key_pressed rises 6 edges after the final stable low is first sampled.
REQ-033 Scenario 4: sw 0000 -> 1111 while key_n goes low on the same edge -> switch_changed and key_pulse each high for exactly one, identical cycle.
REQ-034 Scenario 5: sw held at 1000, reset pulsed for 2 cycles mid-count, then released -> outputs 0 during reset; switch = 1000 6 edges after release with one switch_changed.
REQ-035 Scenario 6: key held 30 cycles after acceptance -> with macro: initial pulse plus pulses every 8 cycles (3 repeats); without macro: exactly 1 pulse.

Source files
------------

// File: rtl/switch_debouncer_if.sv
// Signal bundle between a raw push-button/slide-switch source and switch_debouncer.
// master drives the raw levels; slave (the debouncer) returns the clean levels and strobes.
interface switch_debouncer_if;
    logic       key_n;
    logic [3:0] sw;
    logic       key_pressed;
    logic       key_pulse;
    logic [3:0] switch;
    logic       switch_changed;

    modport master (
        output key_n,
        output sw,
        input  key_pressed,
        input  key_pulse,
        input  switch,
        input  switch_changed
    );

    modport slave (
        input  key_n,
        input  sw,
        output key_pressed,
        output key_pulse,
        output switch,
        output switch_changed
    );
endinterface

// File: rtl/switch_debouncer.sv
// Debouncer for one active-low push-button and four slide switches, with press/change strobes.
// Optional key auto-repeat is compiled in with `define SWITCH_DEBOUNCER_KEY_AUTOREPEAT_EN.
module switch_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_CYCLES   = 8
) (
    input  logic              clock,
    input  logic              reset,
    switch_debouncer_if.slave bus
);
    // Bit 0 is the key (active-high after inversion), bits 4:1 are the switches.
    localparam int                 NBITS     = 5;
    localparam int                 CW        = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]      CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NBITS-1:0]   SYNC_IDLE = 5'b00001;

    logic [NBITS-1:0] raw;
    logic [NBITS-1:0] sync1_q;
    logic [NBITS-1:0] sync2_q;
    logic [NBITS-1:0] samp;
    logic [NBITS-1:0] deb_q;
    logic [NBITS-1:0] deb_d;
    logic [CW-1:0]    cnt_q [NBITS];
    logic [CW-1:0]    cnt_d [NBITS];

    logic             key_prev_q;
    logic             key_rise_q;
    logic [3:0]       sw_prev_q;
    logic             sw_chg_q;

    assign raw  = {bus.sw, bus.key_n};
    assign samp = {sync2_q[NBITS-1:1], ~sync2_q[0]};

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= SYNC_IDLE;
            sync2_q <= SYNC_IDLE;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
        end
    end

    // A bit is accepted once its sample has disagreed with d for DEBOUNCE_CYCLES edges in a row.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NBITS; i++) begin
            cnt_d[i] = '0;
            if (samp[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    deb_d[i] = samp[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            deb_q <= '0;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            deb_q <= deb_d;
            for (int i = 0; i < NBITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Strobes are edge detects on the registered levels, so they trail the level by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_prev_q <= 1'b0;
            key_rise_q <= 1'b0;
            sw_prev_q  <= '0;
            sw_chg_q   <= 1'b0;
        end else begin
            key_prev_q <= deb_q[0];
            key_rise_q <= deb_q[0] & ~key_prev_q;
            sw_prev_q  <= deb_q[NBITS-1:1];
            sw_chg_q   <= (deb_q[NBITS-1:1] != sw_prev_q);
        end
    end

`ifdef SWITCH_DEBOUNCER_KEY_AUTOREPEAT_EN
    localparam int            RW       = $clog2(REPEAT_CYCLES);
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rep_q;
    logic [RW-1:0] rep_d;
    logic          rep_run_q;
    logic          rep_run_d;
    logic          rep_hit;

    // Counting starts the cycle after the initial pulse and stops as soon as the key drops.
    always_comb begin
        rep_hit   = rep_run_q & deb_q[0] & (rep_q == REP_LAST);
        rep_run_d = deb_q[0] & (rep_run_q | key_rise_q);
        rep_d     = '0;
        if (rep_run_q && deb_q[0] && !rep_hit) begin
            rep_d = rep_q + RW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rep_q     <= '0;
            rep_run_q <= 1'b0;
        end else begin
            rep_q     <= rep_d;
            rep_run_q <= rep_run_d;
        end
    end

    assign bus.key_pulse = key_rise_q | rep_hit;
`else
    // The repeat period only matters when auto-repeat is compiled in.
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = (REPEAT_CYCLES != 0);

    assign bus.key_pulse = key_rise_q;
`endif

    assign bus.key_pressed    = deb_q[0];
    assign bus.switch         = deb_q[NBITS-1:1];
    assign bus.switch_changed = sw_chg_q;
endmodule

// File: tb/tb_switch_debouncer.sv
// Self-checking bench for switch_debouncer: directed scenarios plus randomized raw levels,
// checked every cycle against a sample-window reference model.
module tb_switch_debouncer;
    localparam int DC = 4;
    localparam int RC = 8;
`ifdef SWITCH_DEBOUNCER_KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    switch_debouncer_if ifc ();

    switch_debouncer #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_CYCLES  (RC)
    ) dut (
        .clock(clk),
        .reset(rst),
        .bus  (ifc)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Inputs change 7 time units after a rising edge; model and checks see post-edge values.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #7;
        end
    endtask

    // Values the DUT actually sampled at each rising edge.
    logic       lat_rst;
    logic       lat_key_n;
    logic [3:0] lat_sw;
    always @(posedge clk) begin
        lat_rst   <= rst;
        lat_key_n <= ifc.key_n;
        lat_sw    <= ifc.sw;
    end

    // Reference: a bit flips once the DC samples that reached the debouncer (two edges late)
    // all disagree with its level. hist[0] is the level sampled at the latest edge.
    logic [4:0] m_hist [0:DC+1];
    logic [4:0] m_d;
    logic [4:0] m_d1;
    logic [4:0] m_d2;
    int         m_t;
    logic       e_kp;
    logic       e_pulse;
    logic       e_chg;
    logic [3:0] e_sw;

    task model_step();
        logic agree;
        if (lat_rst) begin
            for (int j = 0; j <= DC + 1; j++) m_hist[j] = '0;
            m_d  = '0;
            m_d1 = '0;
            m_d2 = '0;
            m_t  = -1;
        end else begin
            for (int j = DC + 1; j > 0; j--) m_hist[j] = m_hist[j-1];
            m_hist[0] = {lat_sw, ~lat_key_n};
            m_d2 = m_d1;
            m_d1 = m_d;
            for (int b = 0; b < 5; b++) begin
                agree = 1'b1;
                for (int j = 2; j <= DC + 1; j++) begin
                    if (m_hist[j][b] == m_d[b]) agree = 1'b0;
                end
                if (agree) m_d[b] = ~m_d[b];
            end
            if (m_d[0]) m_t = (m_t < 0) ? 0 : m_t + 1;
            else        m_t = -1;
        end
        e_kp    = m_d[0];
        e_sw    = m_d[4:1];
        e_chg   = (m_d1[4:1] != m_d2[4:1]);
        e_pulse = (m_t == 1) || (AR && m_t > 1 && ((m_t - 1) % RC) == 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step();
            chk("key_pressed", ifc.key_pressed, e_kp);
            chk("key_pulse", ifc.key_pulse, e_pulse);
            chk("switch", ifc.switch, e_sw);
            chk("switch_changed", ifc.switch_changed, e_chg);
        end
    end

    int rise_e, chg_e, pul_e, nchg, npul, seen, hold;

    initial begin
        rst       = 1'b1;
        ifc.key_n = 1'b1;
        ifc.sw    = 4'b0000;
        tick(3);
        chk("reset_key_pressed", ifc.key_pressed, 0);
        chk("reset_key_pulse", ifc.key_pulse, 0);
        chk("reset_switch", ifc.switch, 0);
        chk("reset_switch_changed", ifc.switch_changed, 0);
        rst = 1'b0;
        tick(3);

        // Scenario 1: switches 0000 -> 0101
        ifc.sw = 4'b0101;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            chk("s1_switch", ifc.switch, (e >= 6) ? 4'b0101 : 4'b0000);
            chk("s1_changed", ifc.switch_changed, (e == 7) ? 1 : 0);
            chk("s1_key", {ifc.key_pressed, ifc.key_pulse}, 0);
            if (e == 6) chk("s1_model_switch", e_sw, 4'b0101);
        end

        // Scenario 2: 3-cycle key glitch is rejected
        seen = 0;
        ifc.key_n = 1'b0;
        for (int e = 0; e < 3; e++) begin
            tick(1);
            seen |= {ifc.key_pressed, ifc.key_pulse};
        end
        ifc.key_n = 1'b1;
        for (int e = 0; e < 12; e++) begin
            tick(1);
            seen |= {ifc.key_pressed, ifc.key_pulse};
        end
        chk("s2_glitch_rejected", seen, 0);

        // Scenario 3: bouncing press, then a stable low
        npul = 0;
        for (int i = 0; i < 10; i++) begin
            ifc.key_n = (i % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
            npul += int'(ifc.key_pulse);
        end
        ifc.key_n = 1'b0;
        rise_e = 0;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (ifc.key_pressed && rise_e == 0) rise_e = e;
            npul += int'(ifc.key_pulse);
        end
        chk("s3_rise_edge", rise_e, 6);
        chk("s3_pulse_count", npul, 1);
        ifc.key_n = 1'b1;
        ifc.sw    = 4'b0000;
        tick(12);

        // Scenario 4: key and all switches change on the same edge
        ifc.sw    = 4'b1111;
        ifc.key_n = 1'b0;
        nchg = 0; npul = 0; chg_e = 0; pul_e = 0;
        for (int e = 1; e <= 10; e++) begin
            tick(1);
            if (ifc.switch_changed) begin nchg++; chg_e = e; end
            if (ifc.key_pulse) begin npul++; pul_e = e; end
        end
        chk("s4_changed_count", nchg, 1);
        chk("s4_pulse_count", npul, 1);
        chk("s4_changed_edge", chg_e, 7);
        chk("s4_pulse_edge", pul_e, 7);
        ifc.key_n = 1'b1;
        tick(12);

        // Scenario 5: reset mid-count discards progress
        ifc.sw = 4'b1000;
        tick(3);
        rst = 1'b1;
        for (int e = 0; e < 2; e++) begin
            tick(1);
            chk("s5_outputs_in_reset",
                {ifc.key_pressed, ifc.key_pulse, ifc.switch, ifc.switch_changed}, 0);
        end
        rst  = 1'b0;
        nchg = 0;
        for (int e = 1; e <= 9; e++) begin
            tick(1);
            chk("s5_switch", ifc.switch, (e >= 6) ? 4'b1000 : 4'b0000);
            nchg += int'(ifc.switch_changed);
        end
        chk("s5_changed_count", nchg, 1);
        tick(4);

        // Scenario 6: long hold, auto-repeat when compiled in
        ifc.key_n = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick(1);
            if (e == 5) chk("s6_not_yet", ifc.key_pressed, 0);
            if (e == 6) chk("s6_accepted", ifc.key_pressed, 1);
        end
        npul = 0;
        for (int e = 0; e < 30; e++) begin
            tick(1);
            npul += int'(ifc.key_pulse);
        end
        chk("s6_pulse_count", npul, AR ? 4 : 1);
        ifc.key_n = 1'b1;
        tick(12);

        // Randomized levels with occasional resets and long holds
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                tick($urandom_range(1, 2));
                rst = 1'b0;
            end
            ifc.key_n = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) ifc.sw = 4'($urandom);
            else ifc.sw = ifc.sw ^ 4'(1 << $urandom_range(0, 3));
            hold = ($urandom_range(0, 7) == 0) ? $urandom_range(15, 40) : $urandom_range(1, 8);
            tick(hold);
        end
        tick(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
